// File: rtl/btn_conditioner.sv
// Four-channel push-button conditioner: 2-FF synchronizer, per-channel debounce FSM,
// registered level / press / release outputs and optional auto-repeat while held.
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES    = 1000000,
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25000000,
  parameter int unsigned REPEAT_PERIOD = 5000000
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic [3:0] btn_n,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release,
  output logic       any_press
);

  // Counter widths: each counter must be able to hold its parameter value.
  localparam int unsigned DebW   = $clog2(DEB_CYCLES + 1);
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  localparam logic [DebW-1:0] DebLast       = DebW'(DEB_CYCLES - 1);
  localparam logic [DebW-1:0] DebOne        = DebW'(1);
  localparam logic [RepW-1:0] RepDelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] RepPeriodLast = RepW'(REPEAT_PERIOD - 1);
  localparam logic [RepW-1:0] RepOne        = RepW'(1);

  typedef enum logic [1:0] {
    StReleased  = 2'd0,
    StDbPress   = 2'd1,
    StHeld      = 2'd2,
    StDbRelease = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] pressed_s;

  // Next-state for the two synchronizer stages.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
  end

  // Synchronizer flops; reset to the released (high) level.
  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign pressed_s = ~sync2_q;

  // ---------------------------------------------------------------------------
  // Per-channel debounce / repeat FSMs
  // ---------------------------------------------------------------------------
  logic [3:0] level_vec_q;
  logic [3:0] press_vec_q;
  logic [3:0] press_vec_d;
  logic [3:0] release_vec_q;

  for (genvar g = 0; g < 4; g++) begin : g_chan
    state_e          state_q, state_d;
    logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    // Set once the first (REPEAT_DELAY) repeat has fired; later ones use REPEAT_PERIOD.
    logic            rep_phase_q, rep_phase_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic [RepW-1:0] rep_last;

    assign rep_last = rep_phase_q ? RepPeriodLast : RepDelayLast;

    // Channel next-state: debounce both edges, emit one-cycle press/release pulses.
    always_comb begin
      state_d     = state_q;
      deb_cnt_d   = deb_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      rep_phase_d = rep_phase_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      unique case (state_q)
        StReleased: begin
          if (pressed_s[g]) begin
            state_d   = StDbPress;
            deb_cnt_d = DebOne;
          end else begin
            deb_cnt_d = '0;
          end
        end
        StDbPress: begin
          if (!pressed_s[g]) begin
            // Glitch shorter than the debounce window: drop it silently.
            state_d   = StReleased;
            deb_cnt_d = '0;
          end else if (deb_cnt_q == DebLast) begin
            state_d     = StHeld;
            deb_cnt_d   = '0;
            rep_cnt_d   = '0;
            rep_phase_d = 1'b0;
            level_d     = 1'b1;
            press_d     = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt_q + DebOne;
          end
        end
        StHeld: begin
          if (!pressed_s[g]) begin
            // Repeat counter is frozen while the release is being qualified.
            state_d   = StDbRelease;
            deb_cnt_d = DebOne;
          end else if (REPEAT_EN) begin
            if (rep_cnt_q == rep_last) begin
              press_d     = 1'b1;
              rep_cnt_d   = '0;
              rep_phase_d = 1'b1;
            end else begin
              rep_cnt_d = rep_cnt_q + RepOne;
            end
          end
        end
        StDbRelease: begin
          if (pressed_s[g]) begin
            // Release bounce: back to HELD, level never dropped, repeat resumes.
            state_d   = StHeld;
            deb_cnt_d = '0;
          end else if (deb_cnt_q == DebLast) begin
            state_d   = StReleased;
            deb_cnt_d = '0;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            deb_cnt_d = deb_cnt_q + DebOne;
          end
        end
        default: begin
          state_d   = StReleased;
          deb_cnt_d = '0;
        end
      endcase
    end

    // Channel state and registered outputs; reset aborts with no release pulse.
    always_ff @(posedge clk_50MHz) begin
      if (!reset) begin
        state_q     <= StReleased;
        deb_cnt_q   <= '0;
        rep_cnt_q   <= '0;
        rep_phase_q <= 1'b0;
        level_q     <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
      end else begin
        state_q     <= state_d;
        deb_cnt_q   <= deb_cnt_d;
        rep_cnt_q   <= rep_cnt_d;
        rep_phase_q <= rep_phase_d;
        level_q     <= level_d;
        press_q     <= press_d;
        release_q   <= release_d;
      end
    end

    assign level_vec_q[g]   = level_q;
    assign press_vec_q[g]   = press_q;
    assign press_vec_d[g]   = press_d;
    assign release_vec_q[g] = release_q;
  end

  // ---------------------------------------------------------------------------
  // Aggregate press flag, registered alongside btn_press so both align.
  // ---------------------------------------------------------------------------
  logic any_press_q, any_press_d;

  // OR of next-cycle press pulses.
  always_comb begin
    any_press_d = |press_vec_d;
  end

  // any_press register.
  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      any_press_q <= 1'b0;
    end else begin
      any_press_q <= any_press_d;
    end
  end

  assign btn_level   = level_vec_q;
  assign btn_press   = press_vec_q;
  assign btn_release = release_vec_q;
  assign any_press   = any_press_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed self-checking bench for btn_conditioner (DEB_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3), with a second REPEAT_EN=0 instance sharing the inputs.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn_n = 4'hF;

  logic [3:0] btn_level, btn_press, btn_release;
  logic       any_press;
  logic [3:0] nr_level, nr_press, nr_release;
  logic       nr_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_conditioner #(
    .DEB_CYCLES   (4),
    .REPEAT_EN    (1'b1),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clk_50MHz  (clk),
    .reset      (reset),
    .btn_n      (btn_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .any_press  (any_press)
  );

  btn_conditioner #(
    .DEB_CYCLES   (4),
    .REPEAT_EN    (1'b0),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut_nr (
    .clk_50MHz  (clk),
    .reset      (reset),
    .btn_n      (btn_n),
    .btn_level  (nr_level),
    .btn_press  (nr_press),
    .btn_release(nr_release),
    .any_press  (nr_any)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    btn_n = 4'hF;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    btn_n = 4'hF;
    tick();
    checks++;
    if ({btn_level, btn_press, btn_release, any_press} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0", {btn_level, btn_press, btn_release, any_press});
    end
    checks++;
    if ({nr_level, nr_press, nr_release, nr_any} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs_nr got %b want 0", {nr_level, nr_press, nr_release, nr_any});
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_clean_press();
    logic [3:0] exp_level, exp_press;
    do_reset();
    btn_n = 4'b0111;
    for (int i = 0; i <= 8; i++) begin
      tick();
      exp_level = (i >= 5) ? 4'b1000 : 4'b0000;
      exp_press = (i == 5) ? 4'b1000 : 4'b0000;
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL clean_level edge %0d got %b want %b", i, btn_level, exp_level);
      end
      checks++;
      if (btn_press !== exp_press) begin
        errors++;
        $display("FAIL clean_press edge %0d got %b want %b", i, btn_press, exp_press);
      end
      checks++;
      if (btn_release !== 4'b0000) begin
        errors++;
        $display("FAIL clean_release edge %0d got %b want 0000", i, btn_release);
      end
      checks++;
      if (any_press !== (i == 5)) begin
        errors++;
        $display("FAIL clean_any edge %0d got %b want %b", i, any_press, (i == 5));
      end
    end
    btn_n = 4'hF;
  endtask

  task automatic test_glitch();
    do_reset();
    btn_n = 4'b1011;
    for (int i = 0; i <= 14; i++) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release} !== 12'd0) begin
        errors++;
        $display("FAIL glitch edge %0d got %b want 0", i, {btn_level, btn_press, btn_release});
      end
      if (i == 2) btn_n = 4'hF;
    end
  endtask

  task automatic test_hold_repeat();
    logic [3:0] exp_level, exp_press;
    do_reset();
    btn_n = 4'b1101;
    for (int i = 0; i <= 24; i++) begin
      tick();
      exp_level = (i >= 5) ? 4'b0010 : 4'b0000;
      exp_press = (i == 5 || i == 15 || i == 18 || i == 21 || i == 24) ? 4'b0010 : 4'b0000;
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL hold_level edge %0d got %b want %b", i, btn_level, exp_level);
      end
      checks++;
      if (btn_press !== exp_press) begin
        errors++;
        $display("FAIL hold_press edge %0d got %b want %b", i, btn_press, exp_press);
      end
      if (i == 23) btn_n = 4'hF;
    end
  endtask

  // Continues from test_hold_repeat: high at edges 24,25, low at 26, high from 27.
  task automatic test_release_bounce();
    logic [3:0] exp_level, exp_rel;
    for (int i = 25; i <= 40; i++) begin
      tick();
      exp_level = (i <= 31) ? 4'b0010 : 4'b0000;
      exp_rel   = (i == 32) ? 4'b0010 : 4'b0000;
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL bounce_level edge %0d got %b want %b", i, btn_level, exp_level);
      end
      checks++;
      if (btn_release !== exp_rel) begin
        errors++;
        $display("FAIL bounce_release edge %0d got %b want %b", i, btn_release, exp_rel);
      end
      checks++;
      if (btn_press !== 4'b0000) begin
        errors++;
        $display("FAIL bounce_press edge %0d got %b want 0000", i, btn_press);
      end
      if (i == 25) btn_n = 4'b1101;
      if (i == 26) btn_n = 4'hF;
    end
  endtask

  task automatic test_simul_reset();
    logic [3:0] exp_level, exp_press;
    do_reset();
    btn_n = 4'b0000;
    for (int i = 0; i <= 16; i++) begin
      tick();
      exp_level = ((i >= 5 && i <= 7) || i >= 14) ? 4'hF : 4'h0;
      exp_press = (i == 5 || i == 14) ? 4'hF : 4'h0;
      checks++;
      if (btn_level !== exp_level) begin
        errors++;
        $display("FAIL simul_level edge %0d got %b want %b", i, btn_level, exp_level);
      end
      checks++;
      if (btn_press !== exp_press) begin
        errors++;
        $display("FAIL simul_press edge %0d got %b want %b", i, btn_press, exp_press);
      end
      checks++;
      if (btn_release !== 4'h0) begin
        errors++;
        $display("FAIL simul_release edge %0d got %b want 0000", i, btn_release);
      end
      checks++;
      if (any_press !== (i == 5 || i == 14)) begin
        errors++;
        $display("FAIL simul_any edge %0d got %b want %b", i, any_press, (i == 5 || i == 14));
      end
      if (i == 7) reset = 1'b0;
      if (i == 8) reset = 1'b1;
    end
    btn_n = 4'hF;
  endtask

  task automatic test_no_repeat();
    int n_rep;
    int n_nr;
    n_rep = 0;
    n_nr  = 0;
    do_reset();
    btn_n = 4'b1110;
    for (int i = 0; i <= 99; i++) begin
      tick();
      if (btn_press[0] === 1'b1) n_rep++;
      if (nr_press[0] === 1'b1) n_nr++;
      checks++;
      if ((nr_press & nr_release) !== 4'h0 || (btn_press & btn_release) !== 4'h0) begin
        errors++;
        $display("FAIL press_release_overlap edge %0d got %b/%b want no overlap", i,
                 btn_press & btn_release, nr_press & nr_release);
      end
    end
    checks++;
    if (n_nr != 1) begin
      errors++;
      $display("FAIL norepeat_count got %0d want 1", n_nr);
    end
    checks++;
    if (n_rep != 30) begin
      errors++;
      $display("FAIL repeat_count got %0d want 30", n_rep);
    end
    checks++;
    if (nr_level !== 4'b0001) begin
      errors++;
      $display("FAIL norepeat_level got %b want 0001", nr_level);
    end
    btn_n = 4'hF;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_hold_repeat();
    test_release_bounce();
    test_simul_reset();
    test_no_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1000000, consecutive stable samples needed to accept a level change (20 ms at 50 MHz); legal range >= 2.
REQ-002 SHALL have parameter REPEAT_EN, default 1, enables auto-repeat press pulses while a button is held.
REQ-003 SHALL have parameter REPEAT_DELAY, default 25000000, clock cycles in HELD before the first repeat pulse; legal range >= 1.
REQ-004 SHALL have parameter REPEAT_PERIOD, default 5000000, clock cycles between later repeat pulses; legal range >= 1.
REQ-005 SHALL have port clk_50MHz, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 SHALL have port btn_n, input, 4, raw active-low pad buttons {up,down,left,right} = btn_n[3:0], sourced from GPIO_1[11],[13],[15],[17]; asynchronous to clk_50MHz.
REQ-008 SHALL have port btn_level, output, 4, debounced active-high held level per button.
REQ-009 SHALL have port btn_press, output, 4, one-cycle pulse per accepted press and per auto-repeat.
REQ-010 SHALL have port btn_release, output, 4, one-cycle pulse per accepted release.
REQ-011 SHALL have port any_press, output, 1, OR of btn_press, same cycle.

Function
REQ-012 Each btn_n bit SHALL pass through a 2-FF synchronizer; pressed_s = inverted second stage.
REQ-013 The 4 channels SHALL be independent, identical FSMs: RELEASED, DB_PRESS, HELD, DB_RELEASE; no cross-channel interaction.
REQ-014 RELEASED: pressed_s=1 -> DB_PRESS with debounce count=1; otherwise stay, count=0.
REQ-015 DB_PRESS: pressed_s=0 -> RELEASED (glitch rejected, no output); pressed_s=1 and count=DEB_CYCLES-1 -> HELD; else count+1.
REQ-016 On the DB_PRESS->HELD edge, btn_level SHALL go 1 and btn_press SHALL pulse for exactly one cycle.
REQ-017 Latency: if the raw low level is first captured by stage 1 at edge E and held, btn_level/btn_press SHALL be high after edge E+DEB_CYCLES+1.
REQ-018 HELD: pressed_s=0 -> DB_RELEASE with count=1; repeat counter holds its value.
REQ-019 DB_RELEASE: pressed_s=1 -> HELD, btn_level stays 1, no pulse, repeat counter resumes; pressed_s=0 and count=DEB_CYCLES-1 -> RELEASED with btn_level=0 and a one-cycle btn_release pulse; else count+1.
REQ-020 Repeat (REPEAT_EN=1): the repeat counter SHALL clear on HELD entry and advance only for cycles spent in HELD.
REQ-021 If HELD is entered at edge T and occupied continuously, extra btn_press pulses SHALL appear after edges T+REPEAT_DELAY, then every REPEAT_PERIOD edges.
REQ-022 REPEAT_EN=0 SHALL produce exactly one btn_press per accepted press.
REQ-023 Counters SHALL be sized as ceil(log2(param+1)) bits; they SHALL neither wrap nor saturate early.
REQ-024 btn_press and btn_release SHALL never both be high on one channel in the same cycle.
REQ-025 Outputs SHALL be registered; no combinational path from btn_n to any output.

Reset
REQ-026 With reset=0 at a rising edge, synchronizer flops SHALL load 1 (released) and all FSMs SHALL enter RELEASED with counters 0.
REQ-027 During that cycle btn_level, btn_press, btn_release and any_press SHALL be 0.
REQ-028 Reset during DB_PRESS, HELD or DB_RELEASE SHALL abort the channel with no release pulse.
REQ-029 A button held low across reset release SHALL be debounced as a new press per REQ-017.

Verification
(Use DEB_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3 unless stated.)
REQ-030 Clean press: btn_n[3] 1->0, captured at edge 0 -> btn_level[3]=1 and btn_press[3]=1 after edge 5; btn_press[3]=0 after edge 6; any_press mirrors.
REQ-031 Glitch: btn_n[2] low for 3 cycles, then high -> btn_level, btn_press and btn_release all stay 0.
REQ-032 Hold with repeat: btn_n[1] held low from edge 0 -> btn_press[1] pulses after edges 5, 15, 18, 21, 24, ...
REQ-033 Release bounce: from HELD, btn_n[1] high 2 cycles, low 1, then high steady -> btn_level stays 1 through the bounce; btn_release pulses once DEB_CYCLES samples after the last high transition; no extra press.
REQ-034 Simultaneous and reset: all four btn_n low at edge 0 -> all btn_press bits pulse after edge 5 together; reset=0 at edge 8 -> all outputs 0 after edge 8; with buttons still low, presses recur after edge 8+DEB_CYCLES+2 relative to reset release.
REQ-035 REPEAT_EN=0: button held for 100 cycles -> exactly one btn_press pulse.
